// File: rtl/crp16_boot_loader_pkg.sv
// Shared definitions for the CRP16 serial boot loader.
//   state_t            loader FSM state encoding (4 bits)
//   DEFAULT_BASE_ADDR  default RAM word address of the first payload word
//   DEFAULT_SYNC_BYTE  default frame start marker
//   add_byte           running 8-bit checksum step (mod 256)
package crp16_boot_loader_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StLenLo  = 4'd1,
        StLenHi  = 4'd2,
        StDataLo = 4'd3,
        StDataHi = 4'd4,
        StWrite  = 4'd5,
        StCsum   = 4'd6,
        StDone   = 4'd7,
        StError  = 4'd8
    } state_t;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0000;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] add_byte(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/crp16_boot_loader_register.sv
// Generic W-bit register with asynchronous active-low reset to RESET_VALUE.
//   clock  in  1  rising-edge clock
//   reset  in  1  asynchronous reset, active low
//   d      in  W  next value
//   q      out W  registered value
module crp16_boot_loader_register #(
    parameter int unsigned     W           = 8,
    parameter logic [W-1:0]    RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/crp16_boot_loader.sv
// CRP16 serial program loader. Accepts a framed byte stream
// (SYNC, LEN_LO, LEN_HI, 2N little-endian payload bytes, CSUM), writes each
// 16-bit word into program RAM and holds the CPU in reset until the frame
// checksum verifies.
//   clock        in   1   system clock
//   reset        in   1   asynchronous reset, active low
//   rx_data      in   8   incoming byte
//   rx_valid     in   1   rx_data valid
//   rx_ready     out  1   byte accepted when rx_valid & rx_ready at the edge
//   mem_address  out  16  RAM write word address
//   mem_data     out  16  RAM write data
//   mem_wren     out  1   one-cycle write pulse per word
//   cpu_hold     out  1   1 = keep datapath in reset
//   boot_done    out  1   verified image loaded (sticky until reset)
//   boot_error   out  1   checksum mismatch on the last frame
//   word_count   out  16  words written in the current frame
module crp16_boot_loader
    import crp16_boot_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_error,
    output logic [15:0] word_count
);

    state_t      state_q, state_d;
    logic [3:0]  state_bits;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] count_q, count_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  sum_q, sum_d;
    logic        accept;

    assign state_q = state_t'(state_bits);
    assign accept  = rx_valid & rx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        len_d   = len_q;
        lo_d    = lo_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle, StError: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = StLenLo;
                    sum_d   = '0;
                    count_d = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    sum_d      = add_byte(sum_q, rx_data);
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    sum_d       = add_byte(sum_q, rx_data);
                    state_d     = ({rx_data, len_q[7:0]} != 16'd0) ? StDataLo : StCsum;
                end
            end
            StDataLo: begin
                if (accept) begin
                    lo_d    = rx_data;
                    sum_d   = add_byte(sum_q, rx_data);
                    state_d = StDataHi;
                end
            end
            StDataHi: begin
                if (accept) begin
                    data_d  = {rx_data, lo_q};
                    addr_d  = BASE_ADDR + count_q;  // wraps mod 2^16
                    sum_d   = add_byte(sum_q, rx_data);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                count_d = count_q + 16'd1;
                state_d = (count_q + 16'd1 == len_q) ? StCsum : StDataLo;
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data == sum_q) ? StDone : StError;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    crp16_boot_loader_register #(.W(4), .RESET_VALUE(StIdle)) u_state (
        .clock(clock), .reset(reset), .d(state_d), .q(state_bits)
    );
    crp16_boot_loader_register #(.W(16), .RESET_VALUE(BASE_ADDR)) u_addr (
        .clock(clock), .reset(reset), .d(addr_d), .q(addr_q)
    );
    crp16_boot_loader_register #(.W(16), .RESET_VALUE(16'h0000)) u_data (
        .clock(clock), .reset(reset), .d(data_d), .q(data_q)
    );
    crp16_boot_loader_register #(.W(16), .RESET_VALUE(16'h0000)) u_count (
        .clock(clock), .reset(reset), .d(count_d), .q(count_q)
    );
    crp16_boot_loader_register #(.W(16), .RESET_VALUE(16'h0000)) u_len (
        .clock(clock), .reset(reset), .d(len_d), .q(len_q)
    );
    crp16_boot_loader_register #(.W(8), .RESET_VALUE(8'h00)) u_lo (
        .clock(clock), .reset(reset), .d(lo_d), .q(lo_q)
    );
    crp16_boot_loader_register #(.W(8), .RESET_VALUE(8'h00)) u_sum (
        .clock(clock), .reset(reset), .d(sum_d), .q(sum_q)
    );

    // Outputs decode directly from the registered state, so they change only at clock edges
    // (or immediately on reset, which drops any pending write pulse).
    assign rx_ready    = (state_q != StWrite) && (state_q != StDone);
    assign mem_wren    = (state_q == StWrite);
    assign cpu_hold    = (state_q != StDone);
    assign boot_done   = (state_q == StDone);
    assign boot_error  = (state_q == StError);
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_crp16_boot_loader.sv
module tb_crp16_boot_loader;

    localparam logic [15:0] BASE = 16'hFFFE;  // near the top so multi-word frames wrap
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_error;
    logic [15:0] word_count;

    crp16_boot_loader #(.BASE_ADDR(BASE), .SYNC_BYTE(SYNC)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .cpu_hold(cpu_hold), .boot_done(boot_done),
        .boot_error(boot_error), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Monitors: observed writes, stall cycles and accepted bytes.
    logic [31:0] wq[$];
    int          stall_cnt = 0;
    int          acc_cnt = 0;

    always @(negedge clock) begin
        if (reset && mem_wren) wq.push_back({mem_address, mem_data});
        if (reset && !rx_ready && !boot_done) stall_cnt <= stall_cnt + 1;
    end
    always @(posedge clock) begin
        if (reset && rx_valid && rx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            if (rx_ready) begin
                @(posedge clock);
                taken = 1'b1;
            end
            @(negedge clock);
        end
        if (!taken) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Reference frame builder: words little-endian, checksum = byte sum mod 256.
    task automatic build(input logic [15:0] w[$], input bit bad, output logic [7:0] fr[$]);
        int unsigned s;
        logic [15:0] n;
        n = 16'(w.size());
        fr = {};
        fr.push_back(SYNC);
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        s = n[7:0] + n[15:8];
        foreach (w[i]) begin
            fr.push_back(w[i][7:0]);
            fr.push_back(w[i][15:8]);
            s += w[i][7:0] + w[i][15:8];
        end
        s = s % 256;
        if (bad) s = (s + 1 + $urandom_range(0, 254)) % 256;
        fr.push_back(8'(s));
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (gaps && ($urandom % 3 == 0)) idle($urandom_range(1, 2));
        end
        idle(4);
    endtask

    // Compare the writes and status since mark against the expected words.
    task automatic expect_frame(input string tag, input logic [15:0] w[$], input bit good,
                                input int w0, input int s0, input int a0, input int nbytes);
        check({tag, "_nwrites"}, 32'(wq.size() - w0), 32'(w.size()));
        foreach (w[i]) begin
            if (w0 + i < wq.size())
                check({tag, "_write"}, wq[w0 + i], {BASE + 16'(i), w[i]});
        end
        check({tag, "_stalls"}, 32'(stall_cnt - s0), 32'(w.size()));
        check({tag, "_accepted"}, 32'(acc_cnt - a0), 32'(nbytes));
        check({tag, "_done"}, 32'(boot_done), 32'(good));
        check({tag, "_error"}, 32'(boot_error), 32'(!good));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!good));
        check({tag, "_count"}, 32'(word_count), 32'(w.size()));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_wren"}, 32'(mem_wren), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'(BASE));
        check({tag, "_data"}, 32'(mem_data), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(boot_done), 32'd0);
        check({tag, "_error"}, 32'(boot_error), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        logic [15:0] w1[$];
        logic [15:0] w0[$];
        logic [15:0] wr[$];
        logic [7:0]  fr[$];
        logic [7:0]  fe[$];
        logic [7:0]  junk;
        int          mw, ms, ma, nj;
        bit          bad, in_done;

        w1 = '{16'h1234, 16'hABCD};
        w0 = {};
        @(negedge clock);
        @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clock);

        // Test 1 / 5: canonical frame, valid held continuously.
        build(w1, 1'b0, fr);
        check("t1_csum_byte", 32'(fr[7]), 32'h00C0);
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_frame(fr, 1'b0);
        expect_frame("t1", w1, 1'b1, mw, ms, ma, 8);
        check("t1_ready_done", 32'(rx_ready), 32'd0);

        // Test 2: empty frame.
        do_reset();
        build(w0, 1'b0, fe);
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_frame(fe, 1'b0);
        expect_frame("t2", w0, 1'b1, mw, ms, ma, 4);

        // Test 3: bad checksum, then recovery by a fresh empty frame.
        do_reset();
        build(w1, 1'b0, fr);
        fr[7] = 8'hC1;
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_frame(fr, 1'b0);
        expect_frame("t3a", w1, 1'b0, mw, ms, ma, 8);
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_frame(fe, 1'b0);
        expect_frame("t3b", w0, 1'b1, mw, ms, ma, 4);

        // Test 4: leading junk ignored.
        do_reset();
        build(w1, 1'b0, fr);
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        send_frame(fr, 1'b1);
        expect_frame("t4", w1, 1'b1, mw, ms, ma, 11);

        // Test 6: asynchronous reset mid-frame, then a clean rerun.
        do_reset();
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values("t6_midreset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("t6_after");
        build(w1, 1'b0, fr);
        mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
        send_frame(fr, 1'b0);
        expect_frame("t6", w1, 1'b1, mw, ms, ma, 8);

        // Randomized frames with junk, gaps and occasional bad checksums.
        in_done = 1'b1;
        for (int it = 0; it < 12; it++) begin
            if (in_done) do_reset();
            wr = {};
            for (int k = $urandom_range(0, 6); k > 0; k--) wr.push_back(16'($urandom));
            bad = ($urandom % 3 == 0);
            build(wr, bad, fr);
            mw = wq.size(); ms = stall_cnt; ma = acc_cnt;
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h00;
                send_byte(junk);
            end
            send_frame(fr, 1'b1);
            expect_frame("rand", wr, !bad, mw, ms, ma, nj + fr.size());
            in_done = !bad;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
